// File: rtl/prog_loader.sv
// Framed byte-stream program loader: parses SYNC/header/data/checksum frames,
// writes big-endian words to sequential instruction addresses and gates cpu_en.
module prog_loader #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         ADDR_W    = 11,
  parameter int         TIMEOUT   = 1024
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [31:0]       w_instruction,
  output logic              w_enable,
  output logic [ADDR_W-1:0] w_adrs,
  output logic              cpu_en,
  output logic              busy,
  output logic              load_err,
  output logic [ADDR_W:0]   words_written
);

  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR   = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_CSUM  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERROR = 3'd6;

  logic [2:0]        state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [7:0]        hi_q, hi_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [31:0]       word_q, word_d;
  logic [7:0]        csum_q, csum_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic              cpu_en_q, cpu_en_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;

  logic        xfer;
  logic [15:0] hdr16;
  logic        in_frame;

  assign rx_ready = (state_q != S_WRITE);
  assign xfer     = rx_valid & rx_ready;
  assign hdr16    = {hi_q, rx_data};
  assign in_frame = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CSUM);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    hi_d     = hi_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    word_d   = word_q;
    csum_d   = csum_q;
    idle_d   = idle_q;
    words_d  = words_q;
    cpu_en_d = cpu_en_q;
    busy_d   = busy_q;
    err_d    = err_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (xfer && (rx_data == SYNC_BYTE)) begin
          state_d  = S_HDR;
          idx_d    = 2'd0;
          csum_d   = 8'h00;
          idle_d   = '0;
          words_d  = '0;
          cpu_en_d = 1'b0;
          busy_d   = 1'b1;
          err_d    = 1'b0;
        end
      end
      S_HDR: begin
        if (xfer) begin
          csum_d = csum_q ^ rx_data;
          idle_d = '0;
          idx_d  = idx_q + 2'd1;
          case (idx_q)
            2'd0:    hi_d = rx_data;
            2'd1:    addr_d = ADDR_W'(hdr16);
            2'd2:    hi_d = rx_data;
            default: begin
              cnt_d   = hdr16;
              state_d = (hdr16 == 16'd0) ? S_CSUM : S_DATA;
            end
          endcase
        end
      end
      S_DATA: begin
        if (xfer) begin
          csum_d = csum_q ^ rx_data;
          idle_d = '0;
          word_d = {word_q[23:0], rx_data};
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        // Address wraps naturally at 2^ADDR_W.
        addr_d  = addr_q + ADDR_W'(1);
        words_d = words_q + (ADDR_W + 1)'(1);
        cnt_d   = cnt_q - 16'd1;
        idle_d  = '0;
        state_d = (cnt_q == 16'd1) ? S_CSUM : S_DATA;
      end
      S_CSUM: begin
        if (xfer) begin
          idle_d = '0;
          busy_d = 1'b0;
          if (rx_data == csum_q) begin
            state_d  = S_DONE;
            cpu_en_d = 1'b1;
          end else begin
            state_d  = S_ERROR;
            err_d    = 1'b1;
            cpu_en_d = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A stalled source mid-frame aborts once TIMEOUT idle cycles have elapsed.
    if (in_frame && !xfer) begin
      if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
        state_d  = S_ERROR;
        err_d    = 1'b1;
        cpu_en_d = 1'b0;
        busy_d   = 1'b0;
      end else begin
        idle_d = idle_q + IDLE_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      idx_q    <= 2'd0;
      hi_q     <= 8'h00;
      addr_q   <= '0;
      cnt_q    <= 16'd0;
      word_q   <= 32'h0;
      csum_q   <= 8'h00;
      idle_q   <= '0;
      words_q  <= '0;
      cpu_en_q <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      hi_q     <= hi_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      word_q   <= word_d;
      csum_q   <= csum_d;
      idle_q   <= idle_d;
      words_q  <= words_d;
      cpu_en_q <= cpu_en_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  assign w_enable      = (state_q == S_WRITE);
  assign w_instruction = word_q;
  assign w_adrs        = addr_q;
  assign cpu_en        = cpu_en_q;
  assign busy          = busy_q;
  assign load_err      = err_q;
  assign words_written = words_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed frames from the test plan plus
// randomized frames checked against a frame-level reference model.
module tb_prog_loader;
  localparam int         AW   = 11;
  localparam int         TO   = 16;
  localparam logic [7:0] SYNC = 8'hA5;

  logic          clk = 1'b0;
  logic          resetn;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic [31:0]   w_instruction;
  logic          w_enable;
  logic [AW-1:0] w_adrs;
  logic          cpu_en;
  logic          busy;
  logic          load_err;
  logic [AW:0]   words_written;

  prog_loader #(.SYNC_BYTE(SYNC), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .w_instruction(w_instruction), .w_enable(w_enable),
    .w_adrs(w_adrs), .cpu_en(cpu_en), .busy(busy), .load_err(load_err),
    .words_written(words_written)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  fr[$];
  logic [63:0] wq[$];
  logic [63:0] eq[$];
  bit          exp_ok;
  int          exp_n;
  logic        wen_prev = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Capture every write strobe; a strobe must be a single cycle with rx_ready low.
  always @(negedge clk) begin
    if (w_enable === 1'b1) begin
      check("wen_width", 64'(wen_prev), 64'(0));
      check("rdy_in_write", 64'(rx_ready), 64'(0));
      wq.push_back({32'(w_adrs), w_instruction});
    end
    wen_prev <= w_enable;
  end

  initial begin
    #500000;
    $display("FAIL sim_timeout: got no finish expected finish");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit rdy;
    int guard;
    repeat (gap) @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    guard    = 0;
    forever begin
      rdy = rx_ready;
      @(posedge clk);
      @(negedge clk);
      if (rdy) break;
      guard++;
      if (guard > 50) begin
        check("handshake_stall", 64'(0), 64'(1));
        break;
      end
    end
    rx_valid = 1'b0;
  endtask

  // Reference model: expected writes and outcome derived from the frame bytes.
  task automatic expect_frame();
    int a, n, p;
    logic [7:0]  x;
    logic [31:0] w;
    eq.delete();
    a = int'({fr[1], fr[2]}) % (1 << AW);
    n = int'({fr[3], fr[4]});
    x = fr[1] ^ fr[2] ^ fr[3] ^ fr[4];
    p = 5;
    for (int i = 0; i < n; i++) begin
      w = {fr[p], fr[p+1], fr[p+2], fr[p+3]};
      x = x ^ fr[p] ^ fr[p+1] ^ fr[p+2] ^ fr[p+3];
      eq.push_back({32'(a), w});
      a = (a + 1) % (1 << AW);
      p += 4;
    end
    exp_ok = (x == fr[p]);
    exp_n  = n;
  endtask

  task automatic finish_frame();
    check("n_writes", 64'(wq.size()), 64'(eq.size()));
    for (int i = 0; i < eq.size() && i < wq.size(); i++) check("write", wq[i], eq[i]);
    check("cpu_en", 64'(cpu_en), 64'(exp_ok));
    check("load_err", 64'(load_err), 64'(!exp_ok));
    check("busy_end", 64'(busy), 64'(0));
    check("words_written", 64'(words_written), 64'(exp_n));
  endtask

  task automatic run_frame(input int max_gap);
    expect_frame();
    wq.delete();
    foreach (fr[i]) send_byte(fr[i], int'($urandom_range(0, max_gap)));
    finish_frame();
  endtask

  task automatic send_garbage(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom_range(0, 255));
      if (b == SYNC) b = 8'h00;
      send_byte(b, int'($urandom_range(0, 3)));
    end
  endtask

  task automatic gen_frame(input bit bad);
    logic [15:0] a16;
    logic [7:0]  x, b;
    int          n;
    fr.delete();
    a16 = 16'($urandom_range(0, 65535));
    if ($urandom_range(0, 2) == 0) a16 = (a16 & 16'hF800) | 16'h07FE;
    n = int'($urandom_range(0, 4));
    fr.push_back(SYNC);
    fr.push_back(a16[15:8]);
    fr.push_back(a16[7:0]);
    fr.push_back(8'h00);
    fr.push_back(8'(n));
    x = a16[15:8] ^ a16[7:0] ^ 8'(n);
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) b = SYNC;
      fr.push_back(b);
      x = x ^ b;
    end
    if (bad) x = x ^ 8'($urandom_range(1, 255));
    fr.push_back(x);
  endtask

  task automatic check_reset_outputs();
    check("rst_w_instruction", 64'(w_instruction), 64'(0));
    check("rst_w_enable", 64'(w_enable), 64'(0));
    check("rst_w_adrs", 64'(w_adrs), 64'(0));
    check("rst_cpu_en", 64'(cpu_en), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_load_err", 64'(load_err), 64'(0));
    check("rst_words", 64'(words_written), 64'(0));
    check("rst_rx_ready", 64'(rx_ready), 64'(1));
  endtask

  initial begin
    resetn   = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    resetn = 1'b1;
    @(negedge clk);

    // Single word with cycle-exact strobe checks.
    fr = '{8'hA5, 8'h00, 8'h07, 8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h0E};
    expect_frame();
    wq.delete();
    for (int i = 0; i < 8; i++) send_byte(fr[i], int'($urandom_range(0, 2)));
    send_byte(fr[8], 0);
    check("t1_wen", 64'(w_enable), 64'(1));
    check("t1_adrs", 64'(w_adrs), 64'(7));
    check("t1_instr", 64'(w_instruction), 64'(32'h12345678));
    check("t1_ready_low", 64'(rx_ready), 64'(0));
    check("t1_busy", 64'(busy), 64'(1));
    send_byte(fr[9], 0);
    finish_frame();

    // Address wrap.
    fr = '{8'hA5, 8'h07, 8'hFF, 8'h00, 8'h02, 8'hE0, 8'h00, 8'h00, 8'h07,
           8'hC0, 8'h00, 8'h00, 8'h03, 8'hDE};
    run_frame(2);

    // Bad checksum, then a clean frame clears the error.
    fr = '{8'hA5, 8'h00, 8'h07, 8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h0F};
    run_frame(2);
    fr = '{8'hA5, 8'h00, 8'h07, 8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h0E};
    run_frame(2);

    // Zero-count frame.
    fr = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h00, 8'h10};
    run_frame(2);

    // Timeout after data byte 0x34.
    fr = '{8'hA5, 8'h00, 8'h07, 8'h00, 8'h01, 8'h12, 8'h34};
    wq.delete();
    foreach (fr[i]) send_byte(fr[i], int'($urandom_range(0, 2)));
    repeat (TO - 1) @(negedge clk);
    check("to_err_early", 64'(load_err), 64'(0));
    check("to_busy_early", 64'(busy), 64'(1));
    @(negedge clk);
    check("to_err", 64'(load_err), 64'(1));
    check("to_cpu_en", 64'(cpu_en), 64'(0));
    check("to_busy", 64'(busy), 64'(0));
    check("to_no_write", 64'(wq.size()), 64'(0));

    // Reload from DONE, then reset mid-frame.
    fr = '{8'hA5, 8'h00, 8'h07, 8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h0E};
    run_frame(1);
    send_byte(8'h00, 1);
    send_byte(8'hFF, 1);
    check("done_garbage_cpu_en", 64'(cpu_en), 64'(1));
    send_byte(SYNC, 0);
    check("resync_cpu_en", 64'(cpu_en), 64'(0));
    check("resync_busy", 64'(busy), 64'(1));
    check("resync_words", 64'(words_written), 64'(0));
    fr = '{8'h00, 8'h07, 8'h00, 8'h01, 8'h12, 8'h34};
    foreach (fr[i]) send_byte(fr[i], 0);
    resetn = 1'b0;
    #1;
    check_reset_outputs();
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    send_byte(8'h00, 0);
    send_byte(8'hFF, 0);
    check("idle_garbage_busy", 64'(busy), 64'(0));
    fr = '{8'hA5, 8'h00, 8'h07, 8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h0E};
    run_frame(1);

    // Randomized frames with leading garbage and occasional bad checksums.
    for (int k = 0; k < 25; k++) begin
      send_garbage(int'($urandom_range(0, 2)));
      gen_frame($urandom_range(0, 3) == 0);
      run_frame(4);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
